// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus target.
//   - bus_state_e : one-hot FSM state encoding (8 states)
//   - BeUpper/BeLower : bit positions of UDS/LDS inside the 2-bit byte-enable field
//   - SyncStages : depth of the strobe synchronisers
//   - window_hit() : 24-bit address window decode
package m68k_bus_pkg;

  localparam int unsigned SyncStages = 2;

  localparam int unsigned BeUpper = 1;
  localparam int unsigned BeLower = 0;

  typedef enum logic [7:0] {
    StIdle      = 8'b0000_0001,
    StDecode    = 8'b0000_0010,
    StReq       = 8'b0000_0100,
    StWaitRsp   = 8'b0000_1000,
    StSetup     = 8'b0001_0000,
    StHold      = 8'b0010_0000,
    StBerrHold  = 8'b0100_0000,
    StAbortWait = 8'b1000_0000  // master gave up; drain the outstanding response
  } bus_state_e;

  // True when the word address falls in the 2^bits byte window starting at base.
  function automatic logic window_hit(input logic [22:0] a, input logic [23:0] base,
                                      input int unsigned bits);
    logic [23:0] byte_addr;
    byte_addr = {a, 1'b0};
    return (byte_addr >> bits) == (base >> bits);
  endfunction

endpackage

// File: rtl/bus_sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous bus strobes.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, loads RESET_VAL
//   d    - asynchronous input bits
//   q    - synchronised output bits
module bus_sync2
  import m68k_bus_pkg::*;
#(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* async_reg = "true" *) logic [SyncStages-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {SyncStages{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[SyncStages-2:0], d};
    end
  end

  assign q = stage_q[SyncStages-1];

endmodule

// File: rtl/m68k_bus_target.sv
// Responder end of the 68000 asynchronous bus. Bus cycles hitting the window
// [BASE_ADDR, BASE_ADDR + 2^WINDOW_BITS) become one request to the Pi-side logic;
// the response is driven back and the cycle terminated with DTACK.
// Optional feature macro: M68K_TARGET_TIMEOUT_BERR_EN -- terminate with BERR after
// TIMEOUT_CYCLES without a response; when undefined nBERR_OE never asserts.
// Ports:
//   sys_clk, reset                 - clock, async active-high reset
//   nAS_IN/nUDS_IN/nLDS_IN/RnW_IN  - asynchronous bus strobes and direction
//   A_IN, D_IN                     - bus address [23:1] and write data
//   D_OUT, D_OE                    - read data and its output enable
//   nDTACK_OE, nBERR_OE            - 1 = pull the respective open-drain line low
//   req_*                          - request to Pi-side logic (valid/ready)
//   rsp_valid, rsp_rdata           - one-cycle completion pulse and read data
//   busy                           - FSM not idle
module m68k_bus_target
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR      = 24'hE90000,
  parameter int unsigned WINDOW_BITS    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        nAS_IN,
  input  logic        nUDS_IN,
  input  logic        nLDS_IN,
  input  logic        RnW_IN,
  input  logic [22:0] A_IN,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        nDTACK_OE,
  output logic        nBERR_OE,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [23:0] req_addr,
  output logic        req_rnw,
  output logic [1:0]  req_be,
  output logic [15:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if ((BASE_ADDR & ((24'd1 << WINDOW_BITS) - 24'd1)) != 24'd0) begin : gen_bad_base
    $error("BASE_ADDR must be aligned to the window size");
  end

  logic [3:0] strobes_s;
  logic       as_n_s, uds_n_s, lds_n_s, rnw_s;

  // Strobes idle high (negated) and RnW idles as read while in reset.
  bus_sync2 #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_sync (
    .clk(sys_clk),
    .rst(reset),
    .d  ({nAS_IN, nUDS_IN, nLDS_IN, RnW_IN}),
    .q  (strobes_s)
  );

  assign {as_n_s, uds_n_s, lds_n_s, rnw_s} = strobes_s;

  logic ds_any, hit, timeout;
  assign ds_any = !uds_n_s || !lds_n_s;
  // A_IN is only consulted in DECODE, where a synchronised AS guarantees it is stable.
  assign hit    = window_hit(A_IN, BASE_ADDR, WINDOW_BITS);

  bus_state_e  state_q;
  logic [15:0] d_out_q, req_wdata_q;
  logic        d_oe_q, dtack_q, berr_q, req_valid_q, req_rnw_q;
  logic [23:0] req_addr_q;
  logic [1:0]  req_be_q;

`ifdef M68K_TARGET_TIMEOUT_BERR_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] cnt_q;
  logic            cnt_run;

  // Also runs while draining an aborted request so a silent Pi side cannot wedge the FSM.
  assign cnt_run = (state_q == StReq) || (state_q == StWaitRsp) || (state_q == StAbortWait);
  assign timeout = cnt_run && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!cnt_run) begin
      cnt_q <= '0;
    end else if (!timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      dtack_q     <= 1'b0;
      berr_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_rnw_q   <= 1'b1;
      req_be_q    <= '0;
      req_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!as_n_s) state_q <= StDecode;
        end
        StDecode: begin
          if (as_n_s || !hit) begin
            state_q <= StIdle;
          end else if (ds_any) begin
            // Byte address bit 0 is set only for an LDS-only (odd byte) access.
            req_addr_q       <= {A_IN, uds_n_s};
            req_rnw_q        <= rnw_s;
            req_be_q[BeUpper] <= !uds_n_s;
            req_be_q[BeLower] <= !lds_n_s;
            if (!rnw_s) req_wdata_q <= D_IN;
            req_valid_q      <= 1'b1;
            state_q          <= StReq;
          end
        end
        StReq: begin
          // The request is held even if AS drops; an accepted request must be drained.
          if (timeout) begin
            req_valid_q <= 1'b0;
            berr_q      <= 1'b1;
            state_q     <= StBerrHold;
          end else if (req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (as_n_s) begin
            state_q <= rsp_valid ? StIdle : StAbortWait;
          end else if (timeout) begin
            berr_q  <= 1'b1;
            state_q <= StBerrHold;
          end else if (rsp_valid) begin
            d_out_q <= rsp_rdata;
            d_oe_q  <= req_rnw_q;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          // Data has been on the bus for one cycle before DTACK goes out.
          if (as_n_s) begin
            d_oe_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            dtack_q <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (as_n_s) begin
            d_oe_q  <= 1'b0;
            dtack_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        StBerrHold: begin
          if (as_n_s) begin
            berr_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StAbortWait: begin
          if (rsp_valid || timeout) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign D_OUT     = d_out_q;
  // Never drive the data bus while the synchronised direction says write.
  assign D_OE      = d_oe_q && rnw_s;
  assign nDTACK_OE = dtack_q;
  assign nBERR_OE  = berr_q;
  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign req_rnw   = req_rnw_q;
  assign req_be    = req_be_q;
  assign req_wdata = req_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule
